mem_tid_alloc_ctrl: RTL and testbench

- Shares the pool of 2**MemTidWidth memory transaction IDs (DCACHE_MAX_TX) among several cache-side requesters (e.g. miss unit, write buffer, AMO path).
- Grants are round-robin; each grant returns the lowest free TID.
- Records the owner of every outstanding TID so responses route back to the requester that allocated it.
- Sits between the dcache request sources and the memory NoC adapter; also provides flush draining.

---
 rtl/mem_tid_pkg.sv | 20 ++
 rtl/mem_tid_alloc_ctrl_if.sv | 32 +++
 rtl/mem_tid_rr_arb.sv | 48 ++++
 rtl/mem_tid_alloc_ctrl.sv | 97 +++++++++
 tb/tb_mem_tid_alloc_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_tid_pkg.sv
// Shared helpers for the memory transaction-ID allocator.
// Optional feature macro: MEM_TID_RSP_BYPASS_EN (see mem_tid_alloc_ctrl.sv).
package mem_tid_pkg;

   localparam int MemTidWidth = 2;

   // Default-width TID type for users that do not carry their own width.
   typedef logic [MemTidWidth-1:0] tid_t;

   // Pool size for a given TID width.
   function automatic int nr_tid(input int tid_width);
      return 1 << tid_width;
   endfunction

   // Width of a requester index, never narrower than one bit.
   function automatic int owner_w(input int nr_req);
      return (nr_req > 1) ? $clog2(nr_req) : 1;
   endfunction

endpackage

// File: rtl/mem_tid_alloc_ctrl_if.sv
// Request/grant, response and flush signals between the dcache request
// sources (master) and the TID allocator (slave).
interface mem_tid_alloc_ctrl_if
   import mem_tid_pkg::*;
#(
   parameter int NrReq    = 3,
   parameter int TidWidth = 2
);
   localparam int OwnW = owner_w(NrReq);

   logic [NrReq-1:0]    req_i;
   logic [NrReq-1:0]    gnt_o;
   logic [TidWidth-1:0] gnt_tid_o;
   logic                rsp_valid_i;
   logic [TidWidth-1:0] rsp_tid_i;
   logic [OwnW-1:0]     rsp_owner_o;
   logic                flush_i;
   logic                drained_o;
   logic [TidWidth:0]   outstanding_o;
   logic                full_o;
   logic                err_o;

   modport master (
      output req_i, rsp_valid_i, rsp_tid_i, flush_i,
      input  gnt_o, gnt_tid_o, rsp_owner_o, drained_o, outstanding_o, full_o, err_o
   );

   modport slave (
      input  req_i, rsp_valid_i, rsp_tid_i, flush_i,
      output gnt_o, gnt_tid_o, rsp_owner_o, drained_o, outstanding_o, full_o, err_o
   );
endinterface

// File: rtl/mem_tid_rr_arb.sv
// Round-robin arbiter: the first request at or after the pointer wins,
// and the pointer moves just past the winner when a grant is taken.
module mem_tid_rr_arb
   import mem_tid_pkg::*;
#(
   parameter int NrReq = 3
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NrReq-1:0]          i_req,
   input  logic                      i_en,
   output logic [NrReq-1:0]          o_gnt,
   output logic [owner_w(NrReq)-1:0] o_idx
);
   localparam int OwnW = owner_w(NrReq);

   logic [OwnW-1:0] r_ptr;
   logic [OwnW-1:0] w_idx;
   logic            w_found;
   int              w_pos;

   // Scan upward from the pointer with wrap-around for the first request.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_pos   = 0;
      for (int k = 0; k < NrReq; k++) begin
         w_pos = int'(r_ptr) + k;
         if (w_pos >= NrReq) w_pos = w_pos - NrReq;
         if (!w_found && i_req[w_pos]) begin
            w_found = 1'b1;
            w_idx   = OwnW'(w_pos);
         end
      end
   end

   assign o_gnt = (i_en && w_found) ? (NrReq'(1) << w_idx) : '0;
   assign o_idx = w_idx;

   // Pointer advances past the winner only when a grant is issued.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_ptr <= '0;
      end else if (i_en && w_found) begin
         r_ptr <= (w_idx == OwnW'(NrReq - 1)) ? '0 : w_idx + OwnW'(1);
      end
   end
endmodule

// File: rtl/mem_tid_alloc_ctrl.sv
// Memory transaction-ID allocator: hands the lowest free TID to a
// round-robin-selected requester and remembers who owns it so responses
// route back. Optional macro MEM_TID_RSP_BYPASS_EN lets a TID freed by a
// response this cycle be granted again in the same cycle.
module mem_tid_alloc_ctrl
   import mem_tid_pkg::*;
#(
   parameter int NrReq    = 3,
   parameter int TidWidth = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   mem_tid_alloc_ctrl_if.slave  bus
);
   localparam int NrTid = nr_tid(TidWidth);
   localparam int OwnW  = owner_w(NrReq);

   logic [NrTid-1:0]    r_busy;
   logic [OwnW-1:0]     r_owner [NrTid];
   logic [TidWidth:0]   r_cnt;
   logic                r_err;

   logic [NrTid-1:0]    w_rsp_hit;
   logic [NrTid-1:0]    w_free;
   logic [TidWidth-1:0] w_low_tid;
   logic [NrTid-1:0]    w_busy_nxt;
   logic [TidWidth:0]   w_cnt_nxt;
   logic [NrReq-1:0]    w_arb_gnt;
   logic [OwnW-1:0]     w_arb_idx;
   logic                w_en;
   logic                w_grant;
   logic                w_rsp_err;

   // A response only frees a TID that is actually outstanding.
   assign w_rsp_hit = (bus.rsp_valid_i && r_busy[bus.rsp_tid_i])
                      ? (NrTid'(1) << bus.rsp_tid_i) : '0;
   assign w_rsp_err = bus.rsp_valid_i && !r_busy[bus.rsp_tid_i];

`ifdef MEM_TID_RSP_BYPASS_EN
   assign w_free = ~r_busy | w_rsp_hit;
`else
   assign w_free = ~r_busy;
`endif

   // Lowest-index free TID.
   always_comb begin
      w_low_tid = '0;
      for (int i = NrTid - 1; i >= 0; i--) begin
         if (w_free[i]) w_low_tid = TidWidth'(i);
      end
   end

   assign w_en    = !bus.flush_i && (|w_free);
   assign w_grant = |w_arb_gnt;

   mem_tid_rr_arb #(.NrReq(NrReq)) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_req  (bus.req_i),
      .i_en   (w_en),
      .o_gnt  (w_arb_gnt),
      .o_idx  (w_arb_idx)
   );

   // Release before allocate, so a bypassed TID ends up busy again.
   always_comb begin
      w_busy_nxt = r_busy & ~w_rsp_hit;
      if (w_grant) w_busy_nxt[w_low_tid] = 1'b1;
      w_cnt_nxt = '0;
      for (int i = 0; i < NrTid; i++) begin
         w_cnt_nxt = w_cnt_nxt + (TidWidth+1)'(w_busy_nxt[i]);
      end
   end

   // Bitmap, owner table, registered count and sticky error.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_busy <= '0;
         r_cnt  <= '0;
         r_err  <= 1'b0;
         for (int i = 0; i < NrTid; i++) r_owner[i] <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_cnt  <= w_cnt_nxt;
         if (w_rsp_err) r_err <= 1'b1;
         if (w_grant) r_owner[w_low_tid] <= w_arb_idx;
      end
   end

   assign bus.gnt_o         = w_arb_gnt;
   assign bus.gnt_tid_o     = w_grant ? w_low_tid : '0;
   assign bus.rsp_owner_o   = r_owner[bus.rsp_tid_i];
   assign bus.outstanding_o = r_cnt;
   assign bus.full_o        = (r_cnt == (TidWidth+1)'(NrTid));
   assign bus.drained_o     = bus.flush_i && (r_cnt == '0);
   assign bus.err_o         = r_err;
endmodule

// File: tb/tb_mem_tid_alloc_ctrl.sv
// Directed bench for mem_tid_alloc_ctrl with NrReq=3, TidWidth=2.
module tb_mem_tid_alloc_ctrl;
   logic clk_i = 1'b0;
   logic rst_ni;
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_tid_alloc_ctrl_if #(.NrReq(3), .TidWidth(2)) bus ();

   mem_tid_alloc_ctrl #(.NrReq(3), .TidWidth(2)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

   // Advance one clock; inputs are then changed 1ns after the edge.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_i       = 3'b000;
      bus.rsp_valid_i = 1'b0;
      bus.rsp_tid_i   = 2'd0;
      bus.flush_i     = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      idle_inputs();
      cyc();
      cyc();
      #1;
      n_checks++;
      if ({bus.gnt_o, bus.outstanding_o, bus.full_o, bus.err_o, bus.drained_o} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_state got gnt=%b out=%0d full=%b err=%b drained=%b want all 0",
                  bus.gnt_o, bus.outstanding_o, bus.full_o, bus.err_o, bus.drained_o);
      end
      bus.flush_i = 1'b1;
      #1;
      n_checks++;
      if (bus.drained_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_drained got %b want 1", bus.drained_o);
      end
      bus.flush_i = 1'b0;
      rst_ni = 1'b1;
      cyc();
   endtask

   task automatic test_fill();
      logic [2:0] exp_gnt [4];
      exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100; exp_gnt[3] = 3'b001;
      bus.req_i = 3'b111;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (bus.gnt_o !== exp_gnt[i] || bus.gnt_tid_o !== 2'(i)) begin
            n_fail++;
            $display("FAIL fill_grant%0d got gnt=%b tid=%0d want gnt=%b tid=%0d",
                     i, bus.gnt_o, bus.gnt_tid_o, exp_gnt[i], i);
         end
         cyc();
      end
      #1;
      n_checks++;
      if (bus.full_o !== 1'b1 || bus.gnt_o !== 3'b000 || bus.gnt_tid_o !== 2'd0 ||
          bus.outstanding_o !== 3'd4) begin
         n_fail++;
         $display("FAIL fill_full got full=%b gnt=%b tid=%0d out=%0d want 1 000 0 4",
                  bus.full_o, bus.gnt_o, bus.gnt_tid_o, bus.outstanding_o);
      end
   endtask

   task automatic test_full_rsp_grant();
      bus.req_i       = 3'b010;
      bus.rsp_valid_i = 1'b1;
      bus.rsp_tid_i   = 2'd2;
      #1;
      n_checks++;
      if (bus.rsp_owner_o !== 2'd2) begin
         n_fail++;
         $display("FAIL full_rsp_owner got %0d want 2", bus.rsp_owner_o);
      end
`ifdef MEM_TID_RSP_BYPASS_EN
      n_checks++;
      if (bus.gnt_o !== 3'b010 || bus.gnt_tid_o !== 2'd2) begin
         n_fail++;
         $display("FAIL bypass_same_cycle got gnt=%b tid=%0d want 010 2", bus.gnt_o, bus.gnt_tid_o);
      end
      cyc();
      idle_inputs();
      #1;
      n_checks++;
      if (bus.outstanding_o !== 3'd4 || bus.full_o !== 1'b1 || bus.err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL bypass_after got out=%0d full=%b err=%b want 4 1 0",
                  bus.outstanding_o, bus.full_o, bus.err_o);
      end
`else
      n_checks++;
      if (bus.gnt_o !== 3'b000) begin
         n_fail++;
         $display("FAIL full_rsp_nogrant got gnt=%b want 000", bus.gnt_o);
      end
      cyc();
      bus.rsp_valid_i = 1'b0;
      #1;
      n_checks++;
      if (bus.gnt_o !== 3'b010 || bus.gnt_tid_o !== 2'd2 || bus.outstanding_o !== 3'd3) begin
         n_fail++;
         $display("FAIL full_rsp_next got gnt=%b tid=%0d out=%0d want 010 2 3",
                  bus.gnt_o, bus.gnt_tid_o, bus.outstanding_o);
      end
      cyc();
      idle_inputs();
      #1;
      n_checks++;
      if (bus.outstanding_o !== 3'd4 || bus.err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL full_rsp_refill got out=%0d err=%b want 4 0", bus.outstanding_o, bus.err_o);
      end
`endif
   endtask

   // Owners now: tid0->0, tid1->1, tid2->1, tid3->0; RR pointer 2.
   task automatic test_lowest_free();
      bus.rsp_valid_i = 1'b1;
      bus.rsp_tid_i   = 2'd1;
      #1;
      n_checks++;
      if (bus.rsp_owner_o !== 2'd1) begin
         n_fail++;
         $display("FAIL owner_tid1 got %0d want 1", bus.rsp_owner_o);
      end
      cyc();
      bus.rsp_tid_i = 2'd3;
      #1;
      n_checks++;
      if (bus.rsp_owner_o !== 2'd0) begin
         n_fail++;
         $display("FAIL owner_tid3 got %0d want 0", bus.rsp_owner_o);
      end
      cyc();
      bus.rsp_valid_i = 1'b0;
      bus.req_i       = 3'b001;
      #1;
      n_checks++;
      if (bus.outstanding_o !== 3'd2 || bus.gnt_o !== 3'b001 || bus.gnt_tid_o !== 2'd1) begin
         n_fail++;
         $display("FAIL lowest_free1 got out=%0d gnt=%b tid=%0d want 2 001 1",
                  bus.outstanding_o, bus.gnt_o, bus.gnt_tid_o);
      end
      cyc();
      #1;
      n_checks++;
      if (bus.gnt_o !== 3'b001 || bus.gnt_tid_o !== 2'd3) begin
         n_fail++;
         $display("FAIL lowest_free3 got gnt=%b tid=%0d want 001 3", bus.gnt_o, bus.gnt_tid_o);
      end
      cyc();
      bus.req_i = 3'b000;
   endtask

   task automatic test_err();
      bus.rsp_valid_i = 1'b1;
      bus.rsp_tid_i   = 2'd3;
      cyc();
      #1;
      n_checks++;
      if (bus.outstanding_o !== 3'd3 || bus.err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL err_pre got out=%0d err=%b want 3 0", bus.outstanding_o, bus.err_o);
      end
      cyc();
      bus.rsp_valid_i = 1'b0;
      #1;
      n_checks++;
      if (bus.err_o !== 1'b1 || bus.outstanding_o !== 3'd3) begin
         n_fail++;
         $display("FAIL err_set got err=%b out=%0d want 1 3", bus.err_o, bus.outstanding_o);
      end
      cyc();
      cyc();
      #1;
      n_checks++;
      if (bus.err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky got %b want 1", bus.err_o);
      end
   endtask

   // Busy: tid0,1,2; RR pointer 1.
   task automatic test_flush();
      bus.rsp_valid_i = 1'b1;
      bus.rsp_tid_i   = 2'd0;
      cyc();
      bus.rsp_valid_i = 1'b0;
      bus.flush_i     = 1'b1;
      bus.req_i       = 3'b111;
      #1;
      n_checks++;
      if (bus.gnt_o !== 3'b000 || bus.drained_o !== 1'b0 || bus.outstanding_o !== 3'd2) begin
         n_fail++;
         $display("FAIL flush_block got gnt=%b drained=%b out=%0d want 000 0 2",
                  bus.gnt_o, bus.drained_o, bus.outstanding_o);
      end
      cyc();
      bus.rsp_valid_i = 1'b1;
      bus.rsp_tid_i   = 2'd1;
      cyc();
      bus.rsp_tid_i   = 2'd2;
      #1;
      n_checks++;
      if (bus.gnt_o !== 3'b000 || bus.drained_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_mid got gnt=%b drained=%b want 000 0", bus.gnt_o, bus.drained_o);
      end
      cyc();
      bus.rsp_valid_i = 1'b0;
      #1;
      n_checks++;
      if (bus.drained_o !== 1'b1 || bus.outstanding_o !== 3'd0 || bus.gnt_o !== 3'b000) begin
         n_fail++;
         $display("FAIL flush_drained got drained=%b out=%0d gnt=%b want 1 0 000",
                  bus.drained_o, bus.outstanding_o, bus.gnt_o);
      end
      bus.flush_i = 1'b0;
      #1;
      n_checks++;
      if (bus.gnt_o !== 3'b010 || bus.gnt_tid_o !== 2'd0 || bus.drained_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_resume got gnt=%b tid=%0d drained=%b want 010 0 0",
                  bus.gnt_o, bus.gnt_tid_o, bus.drained_o);
      end
      cyc();
      #1;
      n_checks++;
      if (bus.gnt_o !== 3'b100 || bus.gnt_tid_o !== 2'd1) begin
         n_fail++;
         $display("FAIL back_to_back1 got gnt=%b tid=%0d want 100 1", bus.gnt_o, bus.gnt_tid_o);
      end
      cyc();
      #1;
      n_checks++;
      if (bus.gnt_o !== 3'b001 || bus.gnt_tid_o !== 2'd2) begin
         n_fail++;
         $display("FAIL back_to_back2 got gnt=%b tid=%0d want 001 2", bus.gnt_o, bus.gnt_tid_o);
      end
      cyc();
      bus.req_i = 3'b000;
   endtask

   // Three outstanding, RR pointer 1, err set.
   task automatic test_midrun_reset();
      rst_ni = 1'b0;
      cyc();
      rst_ni = 1'b1;
      #1;
      n_checks++;
      if (bus.outstanding_o !== 3'd0 || bus.err_o !== 1'b0 || bus.full_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun_reset got out=%0d err=%b full=%b want 0 0 0",
                  bus.outstanding_o, bus.err_o, bus.full_o);
      end
      bus.req_i = 3'b111;
      #1;
      n_checks++;
      if (bus.gnt_o !== 3'b001 || bus.gnt_tid_o !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_rr got gnt=%b tid=%0d want 001 0", bus.gnt_o, bus.gnt_tid_o);
      end
      cyc();
      bus.req_i       = 3'b000;
      bus.rsp_valid_i = 1'b1;
      bus.rsp_tid_i   = 2'd2;
      cyc();
      bus.rsp_valid_i = 1'b0;
      #1;
      n_checks++;
      if (bus.err_o !== 1'b1 || bus.outstanding_o !== 3'd1) begin
         n_fail++;
         $display("FAIL stale_rsp got err=%b out=%0d want 1 1", bus.err_o, bus.outstanding_o);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_rsp_grant();
      test_lowest_free();
      test_err();
      test_flush();
      test_midrun_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
